ysyx_25020037_ifu: RTL and testbench
====================================

# ysyx_25020037_ifu

Instruction fetch stage of the ysyx_25020037 multi-cycle core; it sits directly upstream of the decode stage and feeds it `{pc, inst}` through the `ifu_valid` / `idu_ready` handshake. It holds the architectural PC and issues one-word reads on an AXI4-Lite-style read channel. It follows execute-stage redirects (`exu_dnpc_valid` / `exu_dnpc`) and optionally serves hits from a small direct-mapped instruction cache.

## Interface
- `RESET_PC`, 32'h3000_0000, PC loaded on reset.
- `ICACHE_LINES`, 16, number of one-word cache lines; power of two, ≥ 2; used only with `YSYX_25020037_ICACHE_EN`.

- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `idu_ready` in 1: decode stage accepts the bundle this cycle.
- `ifu_valid` out 1: `fu_to_du_bus` holds a valid instruction; registered.
- `fu_to_du_bus` out 64: `{pc[31:0], inst[31:0]}`; registered.
- `exu_dnpc_valid` in 1: redirect pulse from execute.
- `exu_dnpc` in 32: redirect target; sampled when `exu_dnpc_valid` = 1.
- `fence_i` in 1: one-cycle pulse; invalidates the cache.
- `ifu_arvalid` out 1, `ifu_araddr` out 32, `ifu_arready` in 1: read address channel.
- `ifu_rvalid` in 1, `ifu_rdata` in 32, `ifu_rresp` in 2, `ifu_rready` out 1: read data channel.
- `ifu_access_fault` out 1: high while stopped on a bus error.

## Operation
- State machine: IDLE, LOOKUP (cache build only), AR, R, HOLD, FAULT.
- **IDLE**
  - Entered only from reset.
  - Goes to LOOKUP (cached build) or AR (uncached build) on the next cycle.
- **LOOKUP** (one cycle)
  - Index = `pc[2+:log2(ICACHE_LINES)]`; tag = the remaining upper PC bits.
  - Hit: load the bus with `{pc, line data}`, go to HOLD.
  - Miss: go to AR.
- **AR**
  - `ifu_arvalid` = 1, `ifu_araddr` = `pc`.
  - On `ifu_arready` go to R.
  - `arvalid` and `araddr` never change before the handshake completes.
- **R**
  - `ifu_rready` = 1.
  - On `ifu_rvalid` with `rresp` = 0: load the bus with `{pc, rdata}`, fill the cache line (cached build), go to HOLD.
  - On `ifu_rvalid` with `rresp` ≠ 0: go to FAULT.
- **HOLD**
  - `ifu_valid` = 1, bus stable.
  - On `idu_ready`: `pc` ← `pc + 4` (wraps modulo 2^32), `ifu_valid` ← 0, go to LOOKUP or AR.
- **FAULT**
  - `ifu_access_fault` = 1, `ifu_valid` = 0.
  - Leaves only on a redirect or reset.
- **Redirect** (`exu_dnpc_valid` = 1)
  - The target is latched into a pending register, overriding any earlier pending target.
  - IDLE, LOOKUP, HOLD, FAULT: `pc` ← target, `ifu_valid` ← 0, go to LOOKUP or AR.
  - AR: the address handshake completes as issued; the response is then discarded.
  - R: the response is discarded with no cache fill and no fault, even if `rresp` ≠ 0. Then `pc` ← pending target, go to LOOKUP or AR.
  - Redirect and `idu_ready` in the same HOLD cycle: the redirect wins and `pc` ← target, not `pc + 4`.
- **Fill**: a line fill and a `fence_i` in the same cycle leave the line invalid.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; state = IDLE.
  - `ifu_valid`, `fu_to_du_bus`, `ifu_arvalid`, `ifu_araddr`, `ifu_rready`, `ifu_access_fault` = 0.
  - All cache valid bits = 0; pending redirect cleared.
- Reset mid-transaction abandons the transaction with no further handshakes.
- First `ifu_arvalid` appears at cycle 2 after `rst` deasserts in the uncached build, and at cycle 3 in the cached build (after a LOOKUP miss).
- Uncached fetch with zero wait states:
  - AR at cycle t (`arready` = 1).
  - R at t+1 (`rvalid` = 1).
  - `ifu_valid` = 1 at t+2.
- Cache hit: LOOKUP at t, `ifu_valid` = 1 at t+1.
- Back-to-back: the next fetch starts the cycle after the `idu_ready` handshake.
- At most one outstanding read.

## Configuration
- `YSYX_25020037_ICACHE_EN` defined:
  - LOOKUP state present.
  - Tag, data and valid arrays of `ICACHE_LINES` entries.
  - `fence_i` clears all valid bits in one cycle.
- `YSYX_25020037_ICACHE_EN` undefined:
  - No arrays and no LOOKUP state; every fetch goes to the bus.
  - `fence_i` is ignored; the port remains.

## Test plan
- **Uncached reset fetch**: release reset, `arready` = `rvalid` = 1, `rdata` = 32'h00000413 → `araddr` = 32'h3000_0000; `ifu_valid` at cycle 4 with bus = `{32'h3000_0000, 32'h00000413}`; next `araddr` = 32'h3000_0004.
- **Backpressure**: hold `idu_ready` = 0 for 5 cycles → `ifu_valid` and the bus are stable; no new `arvalid` until the handshake.
- **Redirect in R**: `exu_dnpc_valid` with `exu_dnpc` = 32'h3000_0100 while waiting for `rvalid` → the response is discarded, `ifu_valid` stays 0, next `araddr` = 32'h3000_0100.
- **Redirect and accept together**: `exu_dnpc_valid` and `idu_ready` in the same HOLD cycle, target 32'h3000_0040 → next fetch address is 32'h3000_0040, not `pc + 4`.
- **Bus error**: `rresp` = 2'b10 → `ifu_access_fault` = 1, `ifu_valid` = 0 indefinitely; a redirect to 32'h3000_0000 clears the fault and refetches.
- **Cache hit and fence_i** (`YSYX_25020037_ICACHE_EN` defined): redirect twice to 32'h3000_0000 → the second fetch has no `arvalid`, `ifu_valid` follows LOOKUP by 1 cycle. After a `fence_i` pulse, the same redirect reissues `arvalid`.

Source files
------------

// File: rtl/ysyx_25020037_ifu_if.sv
// ============================================================================
// Module      : ysyx_25020037_ifu_if
// Description : IFU decode handshake, redirect and AXI4-Lite read channel bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_25020037_ifu_if;
    logic        idu_ready;
    logic        ifu_valid;
    logic [63:0] fu_to_du_bus;
    logic        exu_dnpc_valid;
    logic [31:0] exu_dnpc;
    logic        fence_i;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;
    logic        ifu_access_fault;

    modport master (
        input  idu_ready, exu_dnpc_valid, exu_dnpc, fence_i,
               ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
        output ifu_valid, fu_to_du_bus, ifu_arvalid, ifu_araddr,
               ifu_rready, ifu_access_fault
    );

    modport slave (
        output idu_ready, exu_dnpc_valid, exu_dnpc, fence_i,
               ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
        input  ifu_valid, fu_to_du_bus, ifu_arvalid, ifu_araddr,
               ifu_rready, ifu_access_fault
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_25020037_ifu.sv
// ============================================================================
// Module      : ysyx_25020037_ifu
// Description : Instruction fetch stage; optional direct-mapped I-cache built
//               when YSYX_25020037_ICACHE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020037_ifu #(
    parameter logic [31:0] RESET_PC     = 32'h3000_0000,
    parameter int          ICACHE_LINES = 16
) (
    input wire                   clk,
    input wire                   rst,
    ysyx_25020037_ifu_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
`ifdef YSYX_25020037_ICACHE_EN
        S_LOOKUP = 3'd1,
`endif
        S_AR     = 3'd2,
        S_R      = 3'd3,
        S_HOLD   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

`ifdef YSYX_25020037_ICACHE_EN
    localparam state_t c_FETCH_START = S_LOOKUP;
`else
    localparam state_t c_FETCH_START = S_AR;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [63:0] r_bus;
    logic [63:0] w_bus_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_nxt;

    logic        w_redir;
    logic [31:0] w_target;

    assign w_redir  = bus.exu_dnpc_valid;
    assign w_target = bus.exu_dnpc;

`ifdef YSYX_25020037_ICACHE_EN
    localparam int c_IDX_W = $clog2(ICACHE_LINES);
    localparam int c_TAG_W = 30 - c_IDX_W;

    logic [c_TAG_W-1:0] r_tag [ICACHE_LINES];
    logic [31:0]        r_data [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] r_line_valid;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_hit;
    logic               w_fill;

    assign w_idx = r_pc[2 +: c_IDX_W];
    assign w_tag = r_pc[31 -: c_TAG_W];
    assign w_hit = r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // fence_i has priority so a fill racing an invalidate stays invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_valid <= '0;
        end else if (bus.fence_i) begin
            r_line_valid <= '0;
        end else if (w_fill) begin
            r_line_valid[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.ifu_rdata;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = bus.fence_i | (ICACHE_LINES < 2);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_valid_nxt   = r_valid;
        w_bus_nxt     = r_bus;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
`ifdef YSYX_25020037_ICACHE_EN
        w_fill        = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                w_state_nxt = c_FETCH_START;
            end
`ifdef YSYX_25020037_ICACHE_EN
            S_LOOKUP: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_LOOKUP;
                end else if (w_hit) begin
                    w_bus_nxt   = {r_pc, r_data[w_idx]};
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_AR;
                end
            end
`endif
            S_AR: begin
                // the address phase is never withdrawn; a redirect waits for the response
                if (w_redir) begin
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_target;
                end
                if (bus.ifu_arready) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                if (bus.ifu_rvalid) begin
                    if (w_redir || r_pend) begin
                        w_pc_nxt    = w_redir ? w_target : r_pend_pc;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = c_FETCH_START;
                    end else if (bus.ifu_rresp == 2'b00) begin
                        w_bus_nxt   = {r_pc, bus.ifu_rdata};
                        w_valid_nxt = 1'b1;
`ifdef YSYX_25020037_ICACHE_EN
                        w_fill      = 1'b1;
`endif
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end else if (w_redir) begin
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_target;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_FETCH_START;
                end else if (bus.idu_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_FETCH_START;
                end
            end
            S_FAULT: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = c_FETCH_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
            r_bus     <= '0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_valid   <= w_valid_nxt;
            r_bus     <= w_bus_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    assign bus.ifu_valid        = r_valid;
    assign bus.fu_to_du_bus     = r_bus;
    assign bus.ifu_arvalid      = (r_state == S_AR);
    assign bus.ifu_araddr       = (r_state == S_AR) ? r_pc : 32'h0;
    assign bus.ifu_rready       = (r_state == S_R);
    assign bus.ifu_access_fault = (r_state == S_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020037_ifu.sv
// ============================================================================
// Module      : tb_ysyx_25020037_ifu
// Description : Directed self-checking bench for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020037_ifu;

`ifdef YSYX_25020037_ICACHE_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 0;
`endif

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    ysyx_25020037_ifu_if bus_if ();

    ysyx_25020037_ifu #(
        .RESET_PC     (32'h3000_0000),
        .ICACHE_LINES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        nvec = 0;
        nerr = 0;
        rst                   = 1'b1;
        bus_if.idu_ready      = 1'b0;
        bus_if.exu_dnpc_valid = 1'b0;
        bus_if.exu_dnpc       = 32'h0;
        bus_if.fence_i        = 1'b0;
        bus_if.ifu_arready    = 1'b0;
        bus_if.ifu_rvalid     = 1'b0;
        bus_if.ifu_rdata      = 32'h0;
        bus_if.ifu_rresp      = 2'b00;
        tick();
        tick();

        // reset state
        chk("rst_valid",   64'(bus_if.ifu_valid),        64'd0);
        chk("rst_bus",     bus_if.fu_to_du_bus,          64'd0);
        chk("rst_arvalid", 64'(bus_if.ifu_arvalid),      64'd0);
        chk("rst_araddr",  64'(bus_if.ifu_araddr),       64'd0);
        chk("rst_rready",  64'(bus_if.ifu_rready),       64'd0);
        chk("rst_fault",   64'(bus_if.ifu_access_fault), 64'd0);

        // reset fetch, zero wait states
        bus_if.ifu_arready = 1'b1;
        bus_if.ifu_rvalid  = 1'b1;
        bus_if.ifu_rdata   = 32'h0000_0413;
        rst = 1'b0;
        repeat (1 + c_LAT) tick();
        chk("first_arvalid", 64'(bus_if.ifu_arvalid), 64'd1);
        chk("first_araddr",  64'(bus_if.ifu_araddr),  64'h3000_0000);
        tick();
        chk("first_rready",  64'(bus_if.ifu_rready),  64'd1);
        chk("first_novalid", 64'(bus_if.ifu_valid),   64'd0);
        tick();
        chk("first_valid",   64'(bus_if.ifu_valid),   64'd1);
        chk("first_bus",     bus_if.fu_to_du_bus,     64'h3000_0000_0000_0413);

        // backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid",   64'(bus_if.ifu_valid),   64'd1);
            chk("bp_bus",     bus_if.fu_to_du_bus,     64'h3000_0000_0000_0413);
            chk("bp_arvalid", 64'(bus_if.ifu_arvalid), 64'd0);
        end
        bus_if.idu_ready = 1'b1;
        tick();
        bus_if.idu_ready = 1'b0;
        chk("acc_valid", 64'(bus_if.ifu_valid), 64'd0);
        repeat (c_LAT) tick();
        chk("next_arvalid", 64'(bus_if.ifu_arvalid), 64'd1);
        chk("next_araddr",  64'(bus_if.ifu_araddr),  64'h3000_0004);

        // redirect while waiting for the read response (response also errors)
        bus_if.ifu_rvalid = 1'b0;
        tick();
        chk("rdr_rready", 64'(bus_if.ifu_rready), 64'd1);
        bus_if.exu_dnpc_valid = 1'b1;
        bus_if.exu_dnpc       = 32'h3000_0100;
        tick();
        bus_if.exu_dnpc_valid = 1'b0;
        bus_if.exu_dnpc       = 32'h0;
        bus_if.ifu_rvalid     = 1'b1;
        bus_if.ifu_rdata      = 32'hdead_beef;
        bus_if.ifu_rresp      = 2'b10;
        tick();
        bus_if.ifu_rresp = 2'b00;
        chk("rdr_valid", 64'(bus_if.ifu_valid),        64'd0);
        chk("rdr_fault", 64'(bus_if.ifu_access_fault), 64'd0);
        repeat (c_LAT) tick();
        chk("rdr_arvalid", 64'(bus_if.ifu_arvalid), 64'd1);
        chk("rdr_araddr",  64'(bus_if.ifu_araddr),  64'h3000_0100);

        // redirect and accept in the same HOLD cycle
        bus_if.ifu_rdata = 32'h0000_0013;
        tick();
        tick();
        chk("ra_valid", 64'(bus_if.ifu_valid), 64'd1);
        chk("ra_bus",   bus_if.fu_to_du_bus,   64'h3000_0100_0000_0013);
        bus_if.idu_ready      = 1'b1;
        bus_if.exu_dnpc_valid = 1'b1;
        bus_if.exu_dnpc       = 32'h3000_0040;
        tick();
        bus_if.idu_ready      = 1'b0;
        bus_if.exu_dnpc_valid = 1'b0;
        repeat (c_LAT) tick();
        chk("ra_arvalid", 64'(bus_if.ifu_arvalid), 64'd1);
        chk("ra_araddr",  64'(bus_if.ifu_araddr),  64'h3000_0040);

        // bus error stops the fetch until a redirect
        bus_if.ifu_rresp = 2'b10;
        tick();
        tick();
        bus_if.ifu_rresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            chk("err_fault",   64'(bus_if.ifu_access_fault), 64'd1);
            chk("err_valid",   64'(bus_if.ifu_valid),        64'd0);
            chk("err_arvalid", 64'(bus_if.ifu_arvalid),      64'd0);
            tick();
        end
        bus_if.exu_dnpc_valid = 1'b1;
        bus_if.exu_dnpc       = 32'h3000_0000;
        bus_if.ifu_rdata      = 32'h0000_0413;
        tick();
        bus_if.exu_dnpc_valid = 1'b0;
        chk("clr_fault", 64'(bus_if.ifu_access_fault), 64'd0);
        repeat (c_LAT) tick();
        chk("clr_arvalid", 64'(bus_if.ifu_arvalid), 64'd1);
        chk("clr_araddr",  64'(bus_if.ifu_araddr),  64'h3000_0000);
        tick();
        tick();
        chk("clr_valid", 64'(bus_if.ifu_valid), 64'd1);
        chk("clr_bus",   bus_if.fu_to_du_bus,   64'h3000_0000_0000_0413);

`ifdef YSYX_25020037_ICACHE_EN
        // cache hit: no bus traffic, valid one cycle after LOOKUP
        for (int i = 0; i < 2; i++) begin
            bus_if.exu_dnpc_valid = 1'b1;
            bus_if.exu_dnpc       = 32'h3000_0000;
            tick();
            bus_if.exu_dnpc_valid = 1'b0;
            chk("hit_lookup_valid", 64'(bus_if.ifu_valid),   64'd0);
            chk("hit_lookup_ar",    64'(bus_if.ifu_arvalid), 64'd0);
            tick();
            chk("hit_ar",    64'(bus_if.ifu_arvalid), 64'd0);
            chk("hit_valid", 64'(bus_if.ifu_valid),   64'd1);
            chk("hit_bus",   bus_if.fu_to_du_bus,     64'h3000_0000_0000_0413);
        end
        bus_if.fence_i = 1'b1;
        tick();
        bus_if.fence_i = 1'b0;
        bus_if.exu_dnpc_valid = 1'b1;
        tick();
        bus_if.exu_dnpc_valid = 1'b0;
        tick();
        chk("fence_arvalid", 64'(bus_if.ifu_arvalid), 64'd1);
        chk("fence_araddr",  64'(bus_if.ifu_araddr),  64'h3000_0000);
`endif

        // synchronous reset returns everything to idle
        rst = 1'b1;
        tick();
        chk("rst2_valid",   64'(bus_if.ifu_valid),   64'd0);
        chk("rst2_arvalid", 64'(bus_if.ifu_arvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
